// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared FSM state type, unit index constants and default unit count for the ALU lock arbiter
package alu_arb_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
   localparam int N_UNITS_DEFAULT = 4;
   localparam int UNIT_ADD = 0;
   localparam int UNIT_SUB = 1;
   localparam int UNIT_MUL = 2;
   localparam int UNIT_DIV = 3;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr, wrapping modulo N
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] pick,
   output logic [W-1:0] idx,
   output logic         valid
);
   logic [W-1:0] k;
   // Scan from the farthest slot back toward ptr so the nearest request is the last one written.
   always_comb begin
      k = '0;
      idx = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         k = W'((int'(ptr) + i) % N);
         if (req[k]) begin
            valid = 1'b1;
            idx = k;
         end
      end
      pick = valid ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/alu_lock_arbiter.sv
// alu_lock_arbiter: round-robin mutual-exclusion lock for the add/sub/mul/div units; ALU_ARB_TIMEOUT_EN adds forced revoke after HOLD_MAX grant cycles
module alu_lock_arbiter
   import alu_arb_pkg::*;
#(
   parameter int N_UNITS  = N_UNITS_DEFAULT,
   parameter int HOLD_MAX = 255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_UNITS-1:0]         working,
   output logic [N_UNITS-1:0]         grant,
   output logic                       busy,
   output logic [$clog2(N_UNITS)-1:0] owner
`ifdef ALU_ARB_TIMEOUT_EN
   ,
   output logic                       timeout
`endif
);
   localparam int W = $clog2(N_UNITS);
   arb_state_t state, state_nx;
   logic [N_UNITS-1:0] grant_nx, elig, pick;
   logic [W-1:0] owner_nx, ptr, ptr_nx, pick_idx;
   logic pick_valid, own_req, revoke;
   assign own_req = working[owner];
   assign busy = |grant;
   rr_pick #(.N(N_UNITS)) u_pick (
      .req(elig),
      .ptr(ptr),
      .pick(pick),
      .idx(pick_idx),
      .valid(pick_valid)
   );
`ifdef ALU_ARB_TIMEOUT_EN
   localparam int CW = $clog2(HOLD_MAX + 1);
   logic [CW-1:0] cnt;
   logic [N_UNITS-1:0] mask;
   assign revoke = state == GRANT && own_req && cnt == CW'(HOLD_MAX - 1);
   assign elig = working & ~mask;
   // Hold counter, timeout pulse, and mask that keeps a revoked unit out until its request is seen low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         mask <= '0;
         timeout <= 1'b0;
      end else begin
         cnt <= state == GRANT ? cnt + 1'b1 : '0;
         mask <= (mask | (revoke ? grant : '0)) & working;
         timeout <= revoke;
      end
   end
`else
   assign revoke = 1'b0;
   assign elig = working;
`endif
   // Next-state logic: grant on pick in IDLE, drop on owner release or revoke, advance pointer in RELEASE.
   always_comb begin
      state_nx = state;
      grant_nx = grant;
      owner_nx = owner;
      ptr_nx = ptr;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nx = GRANT;
               grant_nx = pick;
               owner_nx = pick_idx;
            end
         end
         GRANT: begin
            if (!own_req || revoke) begin
               state_nx = RELEASE;
               grant_nx = '0;
            end
         end
         RELEASE: begin
            state_nx = IDLE;
            ptr_nx = owner == W'(N_UNITS - 1) ? '0 : owner + 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end
   // FSM, grant, owner and pointer registers; grant clears asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         owner <= '0;
         ptr <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         owner <= owner_nx;
         ptr <= ptr_nx;
      end
   end
endmodule

// File: tb/tb_alu_lock_arbiter.sv
// tb_alu_lock_arbiter: directed and randomized checks of the ALU lock arbiter against a behavioural model
module tb_alu_lock_arbiter;
   localparam int N = 4;
`ifdef ALU_ARB_TIMEOUT_EN
   localparam int HOLD = 8;
   localparam bit TMO = 1'b1;
`else
   localparam int HOLD = 255;
   localparam bit TMO = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] working = '0;
   logic [N-1:0] grant;
   logic busy;
   logic [1:0] owner;
`ifdef ALU_ARB_TIMEOUT_EN
   logic timeout;
`endif
   int checks = 0;
   int failures = 0;
   int m_own = -1;
   int m_cool = 0;
   int m_ptr = 0;
   int m_last = 0;
   int m_hold = 0;
   bit m_tmo = 1'b0;
   bit m_mask [N];
   int exp_order [5] = '{0, 1, 2, 3, 0};
   logic [N-1:0] w;

   always #5 clk = ~clk;

   alu_lock_arbiter #(.N_UNITS(N), .HOLD_MAX(HOLD)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .working(working),
      .grant(grant),
      .busy(busy),
      .owner(owner)
`ifdef ALU_ARB_TIMEOUT_EN
      ,
      .timeout(timeout)
`endif
   );

   task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own = -1;
      m_cool = 0;
      m_ptr = 0;
      m_last = 0;
      m_hold = 0;
      m_tmo = 1'b0;
      for (int i = 0; i < N; i++) m_mask[i] = 1'b0;
   endtask

   // One clock edge of the lock rules, given the request vector sampled at that edge.
   task automatic model_step(input logic [N-1:0] wv);
      m_tmo = 1'b0;
      if (m_own >= 0) begin
         if (!wv[m_own]) begin
            m_ptr = (m_own + 1) % N;
            m_own = -1;
            m_cool = 1;
         end else if (TMO && m_hold == HOLD - 1) begin
            m_mask[m_own] = 1'b1;
            m_tmo = 1'b1;
            m_ptr = (m_own + 1) % N;
            m_own = -1;
            m_cool = 1;
         end else begin
            m_hold++;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else begin
         for (int j = 0; j < N; j++) begin
            int u;
            u = (m_ptr + j) % N;
            if (m_own < 0 && wv[u] && !m_mask[u]) begin
               m_own = u;
               m_last = u;
               m_hold = 0;
            end
         end
      end
      for (int i = 0; i < N; i++) if (!wv[i]) m_mask[i] = 1'b0;
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0] mg;
      mg = '0;
      if (m_own >= 0) mg[m_own] = 1'b1;
      expect_eq({tag, "_grant"}, 32'(grant), 32'(mg));
      expect_eq({tag, "_busy"}, 32'(busy), 32'(m_own >= 0));
      expect_eq({tag, "_owner"}, 32'(owner), 32'(m_last));
`ifdef ALU_ARB_TIMEOUT_EN
      expect_eq({tag, "_timeout"}, 32'(timeout), 32'(m_tmo));
`endif
   endtask

   task automatic step(input logic [N-1:0] wv, input string tag);
      working = wv;
      @(posedge clk);
      model_step(wv);
      #1 check_model(tag);
   endtask

   task automatic do_reset();
      working = '0;
      rst_n = 1'b0;
      model_reset();
      #2 check_model("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_mask[i] = 1'b0;
      do_reset();
      step(4'b0100, "single_grant");
      expect_eq("single_grant_const", 32'(grant), 32'h4);
      expect_eq("single_owner_const", 32'(owner), 32'd2);
      step(4'b0000, "single_drop");
      expect_eq("single_drop_const", 32'(grant), 32'h0);
      step(4'b0000, "single_release");
      step(4'b0000, "single_idle");

      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(4'b1111, "rr_take");
         expect_eq("rr_order", 32'(owner), 32'(exp_order[k]));
         step(4'b1111, "rr_hold1");
         step(4'b1111, "rr_hold2");
         step(4'b1111 ^ (4'b0001 << exp_order[k]), "rr_drop");
         expect_eq("rr_drop_const", 32'(grant), 32'h0);
         step(4'b1111, "rr_gap");
         expect_eq("rr_gap_const", 32'(grant), 32'h0);
      end

      do_reset();
      step(4'b0010, "ptr_take1");
      step(4'b1010, "ptr_late3");
      step(4'b1001, "ptr_drop1");
      step(4'b1001, "ptr_release");
      step(4'b1001, "ptr_take3");
      expect_eq("ptr_unit3_const", 32'(grant), 32'h8);

      do_reset();
      step(4'b0100, "mid_take");
      #1 rst_n = 1'b0;
      #1 expect_eq("mid_reset_grant", 32'(grant), 32'h0);
      expect_eq("mid_reset_busy", 32'(busy), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1010, "post_reset");
      expect_eq("post_reset_const", 32'(grant), 32'h2);

      do_reset();
      step(4'b0001, "pulse_take0");
      step(4'b0011, "pulse_on");
      step(4'b0001, "pulse_off");
      step(4'b0000, "pulse_drop0");
      step(4'b0000, "pulse_release");
      step(4'b0000, "pulse_idle");
      expect_eq("pulse_never_const", 32'(grant), 32'h0);

`ifdef ALU_ARB_TIMEOUT_EN
      do_reset();
      step(4'b0001, "tmo_take");
      for (int k = 0; k < HOLD - 1; k++) step(4'b0001, "tmo_hold");
      expect_eq("tmo_still_held", 32'(grant), 32'h1);
      step(4'b0001, "tmo_revoke");
      expect_eq("tmo_revoke_grant", 32'(grant), 32'h0);
      expect_eq("tmo_pulse", 32'(timeout), 32'h1);
      step(4'b0001, "tmo_release");
      expect_eq("tmo_pulse_end", 32'(timeout), 32'h0);
      step(4'b0001, "tmo_masked");
      expect_eq("tmo_masked_const", 32'(grant), 32'h0);
      step(4'b0000, "tmo_unmask");
      step(4'b0001, "tmo_regrant");
      expect_eq("tmo_regrant_const", 32'(grant), 32'h1);
`endif

      do_reset();
      w = '0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(0, 4) == 0) w[i] = ~w[i];
         step(w, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
